// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and helpers for the memory port arbiter
// Contents:
//   ADDR_W, DATA_W        bus widths of one mem_ctrl port slice
//   RW_WRITE, RW_READ     rw_flag encodings understood by mem_ctrl
//   arb_state_t           arbiter FSM states
//   rw_legal()            true for an op that results in a memory access
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  function automatic logic rw_legal(input logic [1:0] rw);
    return (rw == RW_READ) || (rw == RW_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rtl/mem_port_arbiter_rr_picker.sv - combinational round-robin winner selection
// Ports:
//   req    in   N    request vector
//   ptr    in   PW   index with highest priority this round
//   grant  out  N    one-hot winner (all zero when no request)
//   idx    out  PW   binary index of the winner
//   any    out  1    at least one request present
module mem_port_arbiter_rr_picker #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Walk the clients starting at ptr, wrapping past N-1, and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int o = 0; o < N; o++) begin
      int c;
      c = int'(ptr) + o;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any      = 1'b1;
        idx      = PW'(c);
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one mem_ctrl port among several clients
// Ports:
//   clk, rst              posedge clock, synchronous active-high reset
//   rdy                   global enable; low freezes state and suppresses pulses
//   cl_req/rw/addr/len/wdata   per-client request bundle (flattened, client k at slice k)
//   cl_gnt, cl_done       one-hot accept and completion pulses
//   cl_err                with cl_done: timed out or illegal op
//   cl_rdata              read data, broadcast, valid with cl_done on reads
//   mc_rw_flag/addr/len/wdata  request slice towards mem_ctrl
//   mc_rdata, mc_busy, mc_done response slice from mem_ctrl
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS    = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic [NUM_CLIENTS-1:0]        cl_req,
  input  logic [2*NUM_CLIENTS-1:0]      cl_rw,
  input  logic [ADDR_W*NUM_CLIENTS-1:0] cl_addr,
  input  logic [2*NUM_CLIENTS-1:0]      cl_len,
  input  logic [DATA_W*NUM_CLIENTS-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]        cl_gnt,
  output logic [NUM_CLIENTS-1:0]        cl_done,
  output logic                          cl_err,
  output logic [DATA_W-1:0]             cl_rdata,
  output logic [1:0]                    mc_rw_flag,
  output logic [ADDR_W-1:0]             mc_addr,
  output logic [1:0]                    mc_len,
  output logic [DATA_W-1:0]             mc_wdata,
  input  logic [DATA_W-1:0]             mc_rdata,
  input  logic                          mc_busy,
  input  logic                          mc_done
);

  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_CLIENTS - 1);

  arb_state_t             state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          cur_idx;
  logic [NUM_CLIENTS-1:0] cur_onehot;
  logic [1:0]             lat_rw;
  logic [WW-1:0]          wdog;

  // Pulses that were on the outputs during a frozen cycle; replayed once rdy returns.
  logic [NUM_CLIENTS-1:0] hold_gnt;
  logic [NUM_CLIENTS-1:0] hold_done;
  logic [1:0]             hold_flag;

  logic [NUM_CLIENTS-1:0] pick_grant;
  logic [PW-1:0]          pick_idx;
  logic                   pick_any;
  logic [1:0]             win_rw;
  logic [ADDR_W-1:0]      win_addr;
  logic [1:0]             win_len;
  logic [DATA_W-1:0]      win_wdata;

  mem_port_arbiter_rr_picker #(.N(NUM_CLIENTS), .PW(PW)) u_picker (
    .req   (cl_req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign win_rw    = cl_rw[2*pick_idx +: 2];
  assign win_addr  = cl_addr[ADDR_W*pick_idx +: ADDR_W];
  assign win_len   = cl_len[2*pick_idx +: 2];
  assign win_wdata = cl_wdata[DATA_W*pick_idx +: DATA_W];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      cur_onehot <= '0;
      lat_rw     <= '0;
      wdog       <= '0;
      hold_gnt   <= '0;
      hold_done  <= '0;
      hold_flag  <= '0;
      cl_gnt     <= '0;
      cl_done    <= '0;
      cl_err     <= 1'b0;
      cl_rdata   <= '0;
      mc_rw_flag <= '0;
      mc_addr    <= '0;
      mc_len     <= '0;
      mc_wdata   <= '0;
    end else if (!rdy) begin
      // Nobody consumed the pulses shown this cycle: park them and go quiet.
      cl_gnt     <= '0;
      cl_done    <= '0;
      mc_rw_flag <= '0;
      hold_gnt   <= hold_gnt | cl_gnt;
      hold_done  <= hold_done | cl_done;
      hold_flag  <= hold_flag | mc_rw_flag;
    end else if ((|hold_gnt) || (|hold_done) || (|hold_flag)) begin
      // Replay the parked pulses before the FSM moves on; cl_err was never cleared.
      cl_gnt     <= hold_gnt;
      cl_done    <= hold_done;
      mc_rw_flag <= hold_flag;
      hold_gnt   <= '0;
      hold_done  <= '0;
      hold_flag  <= '0;
    end else begin
      cl_gnt     <= '0;
      cl_done    <= '0;
      cl_err     <= 1'b0;
      mc_rw_flag <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any && !mc_busy) begin
            cur_idx    <= pick_idx;
            cur_onehot <= pick_grant;
            cl_gnt     <= pick_grant;
            if (rw_legal(win_rw)) begin
              lat_rw     <= win_rw;
              mc_rw_flag <= win_rw;
              mc_addr    <= win_addr;
              mc_len     <= win_len;
              mc_wdata   <= win_wdata;
              state      <= ARB_ISSUE;
            end else begin
              // Rejected without touching memory; move priority on so it cannot hog.
              cl_done <= pick_grant;
              cl_err  <= 1'b1;
              rr_ptr  <= next_ptr(pick_idx);
            end
          end
        end
        ARB_ISSUE: begin
          wdog  <= '0;
          state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // mc_done is checked first so it wins over a simultaneous watchdog expiry.
          if (mc_done) begin
            cl_done <= cur_onehot;
            if (lat_rw == RW_READ) cl_rdata <= mc_rdata;
            rr_ptr  <= next_ptr(cur_idx);
            state   <= ARB_IDLE;
          end else if (wdog == WD_LAST) begin
            cl_done <= cur_onehot;
            cl_err  <= 1'b1;
            rr_ptr  <= next_ptr(cur_idx);
            state   <= ARB_IDLE;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [N-1:0]  cl_req;
  logic [2*N-1:0]  cl_rw;
  logic [32*N-1:0] cl_addr;
  logic [2*N-1:0]  cl_len;
  logic [32*N-1:0] cl_wdata;
  logic [N-1:0]  cl_gnt;
  logic [N-1:0]  cl_done;
  logic          cl_err;
  logic [31:0]   cl_rdata;
  logic [1:0]    mc_rw_flag;
  logic [31:0]   mc_addr;
  logic [1:0]    mc_len;
  logic [31:0]   mc_wdata;
  logic [31:0]   mc_rdata;
  logic          mc_busy;
  logic          mc_done;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  logic mute  = 1'b0;

  mem_port_arbiter #(.NUM_CLIENTS(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .cl_req(cl_req), .cl_rw(cl_rw), .cl_addr(cl_addr), .cl_len(cl_len), .cl_wdata(cl_wdata),
    .cl_gnt(cl_gnt), .cl_done(cl_done), .cl_err(cl_err), .cl_rdata(cl_rdata),
    .mc_rw_flag(mc_rw_flag), .mc_addr(mc_addr), .mc_len(mc_len), .mc_wdata(mc_wdata),
    .mc_rdata(mc_rdata), .mc_busy(mc_busy), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  // Memory controller model on the falling edge: accept a pulse, stay busy for
  // three falling edges, then perform the access and raise done for one cycle.
  logic [7:0]  ram [0:4095];
  logic [1:0]  m_rw;
  logic [31:0] m_addr;
  logic [1:0]  m_len;
  logic [31:0] m_wdata;
  int          cnt;

  always @(negedge clk) begin
    if (rst) begin
      mc_busy  = 1'b0;
      mc_done  = 1'b0;
      mc_rdata = '0;
      cnt      = 0;
      for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
      ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
      ram[12'h104] = 8'h55; ram[12'h105] = 8'h66; ram[12'h106] = 8'h77; ram[12'h107] = 8'h88;
    end else begin
      mc_done = 1'b0;
      if (rdy) begin
        if (mc_busy) begin
          if (cnt == 0) begin
            if (m_rw == 2'b10) begin
              mc_rdata = '0;
              for (int b = 0; b <= int'(m_len); b++) mc_rdata[8*b +: 8] = ram[int'(m_addr[11:0]) + b];
            end else begin
              for (int b = 0; b <= int'(m_len); b++) ram[int'(m_addr[11:0]) + b] = m_wdata[8*b +: 8];
            end
            mc_done = 1'b1;
            mc_busy = 1'b0;
          end else begin
            cnt = cnt - 1;
          end
        end else if (mc_rw_flag != 2'b00) begin
          pulses  = pulses + 1;
          m_rw    = mc_rw_flag;
          m_addr  = mc_addr;
          m_len   = mc_len;
          m_wdata = mc_wdata;
          if (!mute) begin
            mc_busy = 1'b1;
            cnt     = 2;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge; clients drop req once granted.
  task automatic step();
    @(posedge clk);
    #1;
    cl_req = cl_req & ~cl_gnt;
  endtask

  task automatic set_client(input int c, input logic [1:0] rw, input logic [31:0] addr,
                            input logic [1:0] len, input logic [31:0] wd);
    cl_rw[2*c +: 2]     = rw;
    cl_addr[32*c +: 32] = addr;
    cl_len[2*c +: 2]    = len;
    cl_wdata[32*c +: 32] = wd;
    cl_req[c]           = 1'b1;
  endtask

  task automatic wait_gnt(output int idx, output int n);
    n = 0;
    idx = -1;
    do begin
      step();
      n++;
    end while (cl_gnt == '0 && n < 60);
    chk("gnt_within_bound", {31'd0, (n < 60)}, 32'd1);
    for (int i = 0; i < N; i++) if (cl_gnt[i]) idx = i;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (cl_done == '0 && n < 60);
    chk("done_within_bound", {31'd0, (n < 60)}, 32'd1);
  endtask

  initial begin
    int idx;
    int n;
    int p0;
    int order [4];
    logic [31:0] exp_rd [4];

    rst = 1'b1; rdy = 1'b1; cl_req = '0; cl_rw = '0; cl_addr = '0; cl_len = '0; cl_wdata = '0;
    repeat (3) step();
    chk("rst_gnt", {29'd0, cl_gnt}, 32'd0);
    chk("rst_done", {29'd0, cl_done}, 32'd0);
    chk("rst_err", {31'd0, cl_err}, 32'd0);
    chk("rst_rdata", cl_rdata, 32'd0);
    chk("rst_flag", {30'd0, mc_rw_flag}, 32'd0);
    chk("rst_addr", mc_addr, 32'd0);
    rst = 1'b0;

    // Single read by client 0.
    set_client(0, 2'b10, 32'h100, 2'd3, 32'h0);
    step();
    chk("rd_gnt", {29'd0, cl_gnt}, 32'b001);
    chk("rd_flag", {30'd0, mc_rw_flag}, 32'b10);
    chk("rd_addr", mc_addr, 32'h100);
    chk("rd_len", {30'd0, mc_len}, 32'd3);
    step();
    chk("rd_flag_once", {30'd0, mc_rw_flag}, 32'd0);
    chk("rd_gnt_once", {29'd0, cl_gnt}, 32'd0);
    wait_done(n);
    chk("rd_latency", n, 32'd3);
    chk("rd_done", {29'd0, cl_done}, 32'b001);
    chk("rd_data", cl_rdata, 32'h44332211);
    chk("rd_err", {31'd0, cl_err}, 32'd0);
    chk("rd_pulses", pulses, 32'd1);
    step();
    chk("rd_done_once", {29'd0, cl_done}, 32'd0);

    // Contention from reset: all three ask at once, c0 comes back during c2.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_client(0, 2'b10, 32'h100, 2'd3, 32'h0);
    set_client(1, 2'b10, 32'h104, 2'd3, 32'h0);
    set_client(2, 2'b10, 32'h100, 2'd0, 32'h0);
    exp_rd[0] = 32'h44332211; exp_rd[1] = 32'h88776655;
    exp_rd[2] = 32'h00000011; exp_rd[3] = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(idx, n);
      order[i] = idx;
      if (i == 1) chk("cont_gap", n, 32'd1);
      if (i == 2) set_client(0, 2'b10, 32'h100, 2'd3, 32'h0);
      wait_done(n);
      chk("cont_rdata", cl_rdata, exp_rd[i]);
    end
    chk("cont_order0", order[0], 32'd0);
    chk("cont_order1", order[1], 32'd1);
    chk("cont_order2", order[2], 32'd2);
    chk("cont_order3", order[3], 32'd0);

    // Write by client 2: memory updated, read data bus left alone.
    set_client(2, 2'b01, 32'h200, 2'd1, 32'hAABBCCDD);
    wait_gnt(idx, n);
    chk("wr_gnt_idx", idx, 32'd2);
    chk("wr_flag", {30'd0, mc_rw_flag}, 32'b01);
    chk("wr_wdata", mc_wdata, 32'hAABBCCDD);
    wait_done(n);
    chk("wr_done", {29'd0, cl_done}, 32'b100);
    chk("wr_err", {31'd0, cl_err}, 32'd0);
    chk("wr_rdata_kept", cl_rdata, 32'h44332211);
    chk("wr_ram200", {24'd0, ram[12'h200]}, 32'hDD);
    chk("wr_ram201", {24'd0, ram[12'h201]}, 32'hCC);
    chk("wr_ram202", {24'd0, ram[12'h202]}, 32'h00);

    // Timeout: memory swallows the request; 16 WAIT cycles then error completion.
    mute = 1'b1;
    set_client(1, 2'b10, 32'h100, 2'd3, 32'h0);
    wait_gnt(idx, n);
    chk("to_gnt_idx", idx, 32'd1);
    wait_done(n);
    chk("to_latency", n, 32'd17);
    chk("to_done", {29'd0, cl_done}, 32'b010);
    chk("to_err", {31'd0, cl_err}, 32'd1);
    chk("to_rdata_kept", cl_rdata, 32'h44332211);
    mute = 1'b0;
    step();
    chk("to_done_once", {29'd0, cl_done}, 32'd0);

    // Illegal op on client 1: grant and error completion together, no memory pulse.
    p0 = pulses;
    set_client(1, 2'b11, 32'h300, 2'd0, 32'h0);
    step();
    chk("ill_gnt", {29'd0, cl_gnt}, 32'b010);
    chk("ill_done", {29'd0, cl_done}, 32'b010);
    chk("ill_err", {31'd0, cl_err}, 32'd1);
    chk("ill_flag", {30'd0, mc_rw_flag}, 32'd0);
    step();
    chk("ill_quiet_done", {29'd0, cl_done}, 32'd0);
    chk("ill_err_clr", {31'd0, cl_err}, 32'd0);
    chk("ill_pulses", pulses, p0);

    // rdy low for three cycles while ISSUE is showing its pulse.
    p0 = pulses;
    set_client(0, 2'b10, 32'h104, 2'd1, 32'h0);
    step();
    chk("rdy_gnt", {29'd0, cl_gnt}, 32'b001);
    chk("rdy_flag", {30'd0, mc_rw_flag}, 32'b10);
    rdy = 1'b0;
    repeat (3) step();
    chk("rdy_flag_frozen", {30'd0, mc_rw_flag}, 32'd0);
    chk("rdy_gnt_frozen", {29'd0, cl_gnt}, 32'd0);
    rdy = 1'b1;
    step();
    chk("rdy_flag_deferred", {30'd0, mc_rw_flag}, 32'b10);
    wait_done(n);
    chk("rdy_done", {29'd0, cl_done}, 32'b001);
    chk("rdy_rdata", cl_rdata, 32'h00006655);
    chk("rdy_pulses", pulses, p0 + 1);

    // Reset while waiting on memory.
    set_client(2, 2'b10, 32'h100, 2'd3, 32'h0);
    wait_gnt(idx, n);
    chk("rst_mid_gnt_idx", idx, 32'd2);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_gnt", {29'd0, cl_gnt}, 32'd0);
    chk("rst_mid_done", {29'd0, cl_done}, 32'd0);
    chk("rst_mid_err", {31'd0, cl_err}, 32'd0);
    chk("rst_mid_rdata", cl_rdata, 32'd0);
    chk("rst_mid_flag", {30'd0, mc_rw_flag}, 32'd0);
    chk("rst_mid_addr", mc_addr, 32'd0);
    chk("rst_mid_len", {30'd0, mc_len}, 32'd0);
    chk("rst_mid_wdata", mc_wdata, 32'd0);
    rst = 1'b0;
    set_client(0, 2'b10, 32'h100, 2'd3, 32'h0);
    set_client(2, 2'b10, 32'h104, 2'd3, 32'h0);
    wait_gnt(idx, n);
    chk("rst_ptr_first", idx, 32'd0);
    wait_done(n);
    wait_gnt(idx, n);
    chk("rst_ptr_second", idx, 32'd2);
    wait_done(n);
    chk("rst_ptr_rdata", cl_rdata, 32'h88776655);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
